// File: rtl/stack_pkg.sv
// Shared types and helpers for the 4-entry stack controller.
package stack_pkg;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = 3;
  localparam int ADDR_W = 2;

  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL, ERROR} state_t;

  function automatic logic [DEPTH-1:0] therm(input logic [CNT_W-1:0] cnt);
    logic [DEPTH:0] w_t;
    w_t = (5'd1 << cnt) - 5'd1;
    return w_t[DEPTH-1:0];
  endfunction

  function automatic state_t state_of(input logic [CNT_W-1:0] cnt);
    if (cnt == '0)
      return EMPTY;
    else if (cnt == CNT_W'(DEPTH))
      return FULL;
    else
      return PARTIAL;
  endfunction
endpackage

// File: rtl/stack_mem.sv
// Stack storage: one write port, one combinational read port.
module stack_mem
  import stack_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we)
      r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/stack_ctrl.sv
// Push/pop sequencing, occupancy tracking and sticky error handling for the stack.
// state   | meaning
// EMPTY   | count==0
// PARTIAL | count 1..3
// FULL    | count==4
// ERROR   | fault seen; readies low, contents frozen until err_clr
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push_valid,
  input  logic [DATA_W-1:0] push_data,
  output logic              push_ready,
  input  logic              pop_valid,
  output logic              pop_ready,
  output logic [DATA_W-1:0] pop_data,
  output logic              pop_data_valid,
  output logic [DEPTH-1:0]  enable,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              overflow_err,
  output logic              underflow_err,
  input  logic              err_clr
);
  state_t              r_state, w_state_nxt;
  logic [CNT_W-1:0]    r_count, w_count_nxt, w_top;
  logic [DEPTH-1:0]    r_enable;
  logic [DATA_W-1:0]   r_pop_data, w_rdata;
  logic                r_pop_dv, r_ovf, r_unf;
  logic                w_push_hs, w_pop_hs, w_ovf, w_unf, w_we;
  logic [ADDR_W-1:0]   w_waddr;

  assign push_ready = ((r_state != FULL) && (r_state != ERROR)) || ((r_state == FULL) && pop_valid);
  assign pop_ready  = (r_state != EMPTY) && (r_state != ERROR);
  assign w_push_hs  = push_valid && push_ready;
  assign w_pop_hs   = pop_valid && pop_ready;
  assign w_ovf      = (r_state == FULL) && push_valid && !push_ready;
  assign w_unf      = (r_state == EMPTY) && pop_valid && !pop_ready;
  assign w_top      = r_count - 3'd1;

  stack_mem #(.DATA_W(DATA_W)) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (push_data),
    .i_raddr (w_top[ADDR_W-1:0]),
    .o_rdata (w_rdata)
  );

  always_comb begin
    w_count_nxt = r_count;
    w_we        = 1'b0;
    w_waddr     = r_count[ADDR_W-1:0];
    w_state_nxt = r_state;
    // Simultaneous push/pop overwrites the top entry in place.
    if (w_push_hs && w_pop_hs) begin
      w_we    = 1'b1;
      w_waddr = w_top[ADDR_W-1:0];
    end else if (w_push_hs) begin
      w_we        = 1'b1;
      w_count_nxt = r_count + 3'd1;
    end else if (w_pop_hs) begin
      w_count_nxt = w_top;
    end
    case (r_state)
      ERROR:   if (err_clr) w_state_nxt = state_of(r_count);
      default: w_state_nxt = (w_ovf || w_unf) ? ERROR : state_of(w_count_nxt);
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= EMPTY;
      r_count    <= '0;
      r_enable   <= '0;
      r_pop_data <= '0;
      r_pop_dv   <= 1'b0;
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_count  <= w_count_nxt;
      r_enable <= therm(w_count_nxt);
      r_pop_dv <= w_pop_hs;
      if (w_pop_hs)
        r_pop_data <= w_rdata;
      r_ovf <= (r_ovf && !err_clr) || w_ovf;
      r_unf <= (r_unf && !err_clr) || w_unf;
    end
  end

  assign count          = r_count;
  assign enable         = r_enable;
  assign full           = (r_count == CNT_W'(DEPTH));
  assign empty          = (r_count == '0);
  assign pop_data       = r_pop_data;
  assign pop_data_valid = r_pop_dv;
  assign overflow_err   = r_ovf;
  assign underflow_err  = r_unf;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a queue-based reference model checked every cycle.
module tb_stack_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       push_valid = 1'b0;
  logic [7:0] push_data = 8'h00;
  logic       push_ready;
  logic       pop_valid = 1'b0;
  logic       pop_ready;
  logic [7:0] pop_data;
  logic       pop_data_valid;
  logic [3:0] enable;
  logic [2:0] count;
  logic       full, empty, overflow_err, underflow_err;
  logic       err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  stack_ctrl #(.DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .push_valid(push_valid), .push_data(push_data), .push_ready(push_ready),
    .pop_valid(pop_valid), .pop_ready(pop_ready),
    .pop_data(pop_data), .pop_data_valid(pop_data_valid),
    .enable(enable), .count(count), .full(full), .empty(empty),
    .overflow_err(overflow_err), .underflow_err(underflow_err),
    .err_clr(err_clr)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a LIFO queue plus error bookkeeping.
  logic [7:0] m_stk[$];
  bit         m_err = 1'b0, m_ovf = 1'b0, m_unf = 1'b0, m_pdv = 1'b0;
  logic [7:0] m_pdata = 8'h00;

  function automatic bit m_push_rdy();
    return !m_err && (m_stk.size() < 4 || pop_valid);
  endfunction

  function automatic bit m_pop_rdy();
    return !m_err && m_stk.size() > 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit pa, oa, fo, fu;
    if (!rst_n) begin
      m_stk.delete();
      m_err = 0; m_ovf = 0; m_unf = 0; m_pdv = 0; m_pdata = 8'h00;
    end else begin
      pa = push_valid && m_push_rdy();
      oa = pop_valid && m_pop_rdy();
      fo = !m_err && push_valid && !m_push_rdy();
      fu = !m_err && pop_valid && m_stk.size() == 0;
      m_pdv = oa;
      if (m_err) begin
        if (err_clr) begin
          m_err = 0; m_ovf = 0; m_unf = 0;
        end
      end else begin
        if (oa) begin
          m_pdata = m_stk[$];
          void'(m_stk.pop_back());
        end
        if (pa) m_stk.push_back(push_data);
        if (err_clr) begin m_ovf = 0; m_unf = 0; end
        if (fo) m_ovf = 1;
        if (fu) m_unf = 1;
        m_err = fo || fu;
      end
    end
  end

  always @(negedge clk) begin
    int sz;
    logic [3:0] e;
    sz = m_stk.size();
    e = 4'b0000;
    for (int k = 0; k < 4; k++) e[k] = (k < sz);
    chk("m_count", 32'(count), 32'(sz));
    chk("m_enable", 32'(enable), 32'(e));
    chk("m_full", 32'(full), 32'(sz == 4));
    chk("m_empty", 32'(empty), 32'(sz == 0));
    chk("m_push_ready", 32'(push_ready), 32'(m_push_rdy()));
    chk("m_pop_ready", 32'(pop_ready), 32'(m_pop_rdy()));
    chk("m_pop_dv", 32'(pop_data_valid), 32'(m_pdv));
    if (m_pdv) chk("m_pop_data", 32'(pop_data), 32'(m_pdata));
    chk("m_ovf", 32'(overflow_err), 32'(m_ovf));
    chk("m_unf", 32'(underflow_err), 32'(m_unf));
  end

  task automatic step(input bit pv, input logic [7:0] pd, input bit ov, input bit clr);
    push_valid = pv; push_data = pd; pop_valid = ov; err_clr = clr;
    @(posedge clk);
    #1;
    push_valid = 0; pop_valid = 0; err_clr = 0;
    #1;
  endtask

  logic [3:0] exp_en [4] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};

  initial begin
    #1 rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_enable", 32'(enable), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_pop_data", 32'(pop_data), 0);
    chk("rst_pop_dv", 32'(pop_data_valid), 0);
    rst_n = 1;
    #1;

    for (int i = 0; i < 4; i++) begin
      step(1, 8'(8'hA1 + i), 0, 0);
      chk("push_enable", 32'(enable), 32'(exp_en[i]));
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_push_ready", 32'(push_ready), 0);

    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0);
      chk("drain_pop_data", 32'(pop_data), 32'(8'hA4 - i));
      chk("drain_pop_dv", 32'(pop_data_valid), 1);
    end
    chk("drain_empty", 32'(empty), 1);
    chk("drain_enable", 32'(enable), 0);

    step(1, 8'h11, 0, 0);
    step(1, 8'h22, 0, 0);
    step(1, 8'h55, 1, 0);
    chk("swap_pop_data", 32'(pop_data), 32'h22);
    chk("swap_count", 32'(count), 2);
    step(0, 8'h00, 1, 0);
    chk("swap_new_top", 32'(pop_data), 32'h55);
    step(0, 8'h00, 1, 0);
    chk("swap_bottom", 32'(pop_data), 32'h11);

    step(0, 8'h00, 1, 0);
    chk("unf_flag", 32'(underflow_err), 1);
    chk("unf_pop_ready", 32'(pop_ready), 0);
    chk("unf_push_ready", 32'(push_ready), 0);
    step(1, 8'h33, 0, 0);
    chk("err_push_frozen", 32'(count), 0);
    chk("err_no_ovf", 32'(overflow_err), 0);
    step(0, 8'h00, 0, 1);
    chk("unf_clr_flag", 32'(underflow_err), 0);
    chk("unf_clr_empty", 32'(empty), 1);
    chk("unf_clr_push_ready", 32'(push_ready), 1);

    for (int i = 0; i < 4; i++) step(1, 8'(8'hB1 + i), 0, 0);
    step(1, 8'hEE, 0, 0);
    chk("ovf_flag", 32'(overflow_err), 1);
    chk("ovf_count", 32'(count), 4);
    step(0, 8'h00, 0, 1);
    chk("ovf_clr_flag", 32'(overflow_err), 0);
    chk("ovf_clr_full", 32'(full), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 8'h00, 1, 0);
      chk("ovf_preserved", 32'(pop_data), 32'(8'hB4 - i));
    end

    step(1, 8'h77, 1, 0);
    chk("emp_both_count", 32'(count), 1);
    chk("emp_both_unf", 32'(underflow_err), 1);
    chk("emp_both_no_dv", 32'(pop_data_valid), 0);
    step(0, 8'h00, 0, 1);
    chk("emp_both_pop_ready", 32'(pop_ready), 1);
    step(0, 8'h00, 1, 0);
    chk("emp_both_pop", 32'(pop_data), 32'h77);

    for (int i = 0; i < 4; i++) step(1, 8'(8'hC1 + i), 0, 0);
    step(1, 8'h99, 1, 0);
    chk("full_swap_pop", 32'(pop_data), 32'hC4);
    chk("full_swap_count", 32'(count), 4);
    step(0, 8'h00, 1, 0);
    chk("full_swap_top", 32'(pop_data), 32'h99);

    pop_valid = 1;
    #2;
    rst_n = 0;
    #1;
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_empty", 32'(empty), 1);
    chk("mid_rst_enable", 32'(enable), 0);
    chk("mid_rst_pop_data", 32'(pop_data), 0);
    @(posedge clk);
    #1;
    chk("mid_rst_no_dv", 32'(pop_data_valid), 0);
    pop_valid = 0;
    rst_n = 1;
    #1;
    step(0, 8'h00, 0, 0);
    chk("post_rst_no_dv", 32'(pop_data_valid), 0);
    chk("post_rst_empty", 32'(empty), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/stack_ctrl.md
# stack_ctrl

Sequencing controller for the 4-entry stack datapath: accepts push and pop requests over valid/ready handshakes, owns the stack storage and top-of-stack pointer, and flags overflow and underflow. It drives the 4-bit thermometer occupancy vector `enable` consumed by the occupancy-count decoder, plus a registered `count`. It sits between the requesting FSM logic and the stack storage.

## Interface
- `DEPTH`, 4, number of stack entries; fixed at 4 because `enable` is 4 bits.
- `DATA_W`, 8, width of one stack entry.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `push_valid`  in  1  push request.
- `push_data`  in  `DATA_W`  data to push; sampled on push handshake.
- `push_ready`  out  1  a push is accepted this cycle.
- `pop_valid`  in  1  pop request.
- `pop_ready`  out  1  a pop is accepted this cycle.
- `pop_data`  out  `DATA_W`  popped entry; registered.
- `pop_data_valid`  out  1  one-cycle pulse; `pop_data` is valid.
- `enable`  out  4  thermometer occupancy: 0000, 0001, 0011, 0111, 1111 for 0 to 4 entries.
- `count`  out  3  occupancy, 0 to 4.
- `full`, `empty`  out  1  `count==4`, `count==0`.
- `overflow_err`, `underflow_err`  out  1  sticky error flags.
- `err_clr`  in  1  clears both error flags and leaves ERROR.

## Operation
- FSM states:
  - EMPTY: `count==0`.
  - PARTIAL: `count` 1 to 3.
  - FULL: `count==4`.
  - ERROR: entered on a fault.
- Ready signals:
  - `push_ready = (state!=FULL && state!=ERROR) || (state==FULL && pop_valid)`.
  - `pop_ready = state!=EMPTY && state!=ERROR`.
- Push handshake (valid and ready) with no pop: write `push_data` at index `count`, then `count+1`.
- Pop handshake with no push: `pop_data <= mem[count-1]`, pulse `pop_data_valid`, then `count-1`.
- Simultaneous push and pop, both handshaking (PARTIAL or FULL): `pop_data <= mem[count-1]`, `mem[count-1] <= push_data`, `count` unchanged, `pop_data_valid` pulses.
- In EMPTY, simultaneous push and pop: the push is accepted and the pop is an underflow.
- Fault conditions:
  - `push_valid && !push_ready` in FULL sets `overflow_err`.
  - `pop_valid && !pop_ready` in EMPTY sets `underflow_err`.
  - Either fault moves the FSM to ERROR in the next cycle.
- A request that is not accepted while already in ERROR sets no further flag and changes no state.
- ERROR:
  - Both readies are low; contents and `count` are frozen.
  - `err_clr` clears the flags and returns to EMPTY, PARTIAL or FULL, derived from `count`.
  - `err_clr` outside ERROR clears the flags only.
- Next-state selection from `count`: 0 gives EMPTY, 4 gives FULL, otherwise PARTIAL.
- `enable` is `(1<<count)-1`, registered alongside `count`; it never shows a non-thermometer pattern.

## Timing
- Reset (asynchronous assert, synchronous release): state EMPTY, `count=0`, `enable=0000`, `empty=1`, `full=0`, `pop_data=0`, `pop_data_valid=0`, both error flags 0, memory contents don't-care.
- Readies are combinational from state and `pop_valid`; no combinational path from `push_valid` to any output.
- Pop latency: 1 cycle from handshake edge to `pop_data`/`pop_data_valid`.
- `count`, `enable`, `full`, `empty` update on the edge following the handshake.
- Error flags assert on the edge following the faulting request; ERROR is entered on that same edge.
- `rst_n` asserted mid-operation: immediate return to reset values, and any in-flight `pop_data_valid` is dropped.

## Structure
- Package `stack_pkg`:
  - `state_t` enum {EMPTY, PARTIAL, FULL, ERROR}.
  - `DEPTH` constant, `CNT_W=3`.
  - Function `therm(count)` returning the 4-bit `enable`.
- Sub-module `stack_mem`: DEPTH×DATA_W register file with one write port and one read port, read addressed by `count-1`.
- `stack_ctrl` holds the FSM, the `count` register, handshakes and error logic.

## Test plan
- Reset, then 4 pushes (0xA1 to 0xA4): `enable` steps 0001, 0011, 0111, 1111; `full=1`, `push_ready=0`.
- From full, 4 pops: `pop_data` returns 0xA4, 0xA3, 0xA2, 0xA1, each 1 cycle after its handshake; ends `empty=1`, `enable=0000`.
- With `count=2`, simultaneous push 0x55 and pop: `pop_data` equals the old top, `count` stays 2, and a subsequent pop returns 0x55.
- Pop when empty: `underflow_err=1` next cycle, state ERROR, both readies 0; `err_clr` returns to EMPTY with flags 0.
- Push when full with no pop: `overflow_err=1`, contents preserved; after `err_clr`, 4 pops return the original data.
- Assert `rst_n` during a pop handshake: outputs reach reset values immediately, and there is no `pop_data_valid` pulse.
